// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the oversampled I2C register slave.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    IDX,
    WR,
    RD
  } state_t;

  // Level on SDA during the acknowledge bit
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Value returned when reading an index outside the register/status map
  localparam logic [7:0] RD_FILL = 8'hFF;

endpackage

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: SCL/SDA synchronisation, optional glitch filter and bus
// condition detection. Define I2C_GLITCH_FILTER_EN to add a 3-sample
// majority filter after each synchroniser (+2 clk latency).
module i2c_bus_cond (
  input  logic clk,
  input  logic start_rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [1:0] scl_sync_q, scl_sync_d;
  logic [1:0] sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d;
  logic       sda_prev_q, sda_prev_d;
  logic       scl_f, sda_f;

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] scl_hist_q, scl_hist_d;
  logic [2:0] sda_hist_q, sda_hist_d;

  // Majority of the last three synchronised samples rejects 1-clk pulses
  always_comb begin
    scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
    sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
    scl_f = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
            (scl_hist_q[1] & scl_hist_q[2]);
    sda_f = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
            (sda_hist_q[1] & sda_hist_q[2]);
  end

  // Filter history registers, idle-high after reset
  always_ff @(posedge clk or posedge start_rst) begin
    if (start_rst) begin
      scl_hist_q <= '1;
      sda_hist_q <= '1;
    end else begin
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end
`else
  assign scl_f = scl_sync_q[1];
  assign sda_f = sda_sync_q[1];
`endif

  // Next-state for synchronisers and edge-detect history
  always_comb begin
    scl_sync_d = {scl_sync_q[0], scl_i};
    sda_sync_d = {sda_sync_q[0], sda_i};
    scl_prev_d = scl_f;
    sda_prev_d = sda_f;
  end

  // Synchroniser and previous-sample flops; bus idles high
  always_ff @(posedge clk or posedge start_rst) begin
    if (start_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_prev_q <= scl_prev_d;
      sda_prev_q <= sda_prev_d;
    end
  end

  assign scl_rise = scl_f & ~scl_prev_q;
  assign scl_fall = ~scl_f & scl_prev_q;
  assign start    = scl_f & scl_prev_q & sda_prev_q & ~sda_f;
  assign stop     = scl_f & scl_prev_q & ~sda_prev_q & sda_f;
  assign sda_s    = sda_f;

endmodule

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: clk-oversampled I2C slave with N_RW read/write registers
// and an N_RO-byte read-only status window. Optional glitch filter is
// enabled with I2C_GLITCH_FILTER_EN (see i2c_bus_cond).
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h55,
  parameter int         N_RW     = 24,
  parameter int         N_RO     = 1,
  parameter int         IDX_W    = 8
) (
  input  logic                clk,
  input  logic                start_rst,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe,
  input  logic [N_RO*8-1:0]   status_i,
  output logic [N_RW*8-1:0]   regs_o,
  output logic                wr_stb,
  output logic [IDX_W-1:0]    wr_idx,
  output logic [7:0]          wr_data,
  output logic                busy
);
  import i2c_pkg::*;

  localparam int               TOTAL    = N_RW + N_RO;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  logic scl_rise, scl_fall, start, stop, sda_s;

  i2c_bus_cond u_bus_cond (
    .clk      (clk),
    .start_rst(start_rst),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop),
    .sda_s    (sda_s)
  );

  state_t             state_q, state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         tx_q, tx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               ack_q, ack_d;
  logic               mack_q, mack_d;
  logic               sda_oe_q, sda_oe_d;
  logic               busy_q, busy_d;
  logic [N_RW*8-1:0]  regs_q, regs_d;
  logic               wr_stb_q, wr_stb_d;
  logic [IDX_W-1:0]   wr_idx_q, wr_idx_d;
  logic [7:0]         wr_data_q, wr_data_d;

  logic               ptr_in_rng, ptr_is_rw, idx_ok, ack_bit;
  logic [IDX_W-1:0]   ptr_inc, load_ptr;
  logic [7:0]         rd_src;

  assign ptr_in_rng = int'(ptr_q) < TOTAL;
  assign ptr_is_rw  = int'(ptr_q) < N_RW;
  assign idx_ok     = int'(shift_q) < TOTAL;
  assign ptr_inc    = (ptr_q == LAST_IDX) ? '0 : ptr_q + 1'b1;
  // Entering RD from ADDR reads at the pointer; a master ACK reads the next one
  assign load_ptr   = (state_q == RD) ? ptr_inc : ptr_q;

  // Read byte source: register, status snapshot, or fill
  always_comb begin
    rd_src = RD_FILL;
    for (int unsigned k = 0; k < N_RW; k++)
      if (load_ptr == IDX_W'(k)) rd_src = regs_q[k*8 +: 8];
    for (int unsigned k = 0; k < N_RO; k++)
      if (load_ptr == IDX_W'(N_RW + k)) rd_src = status_i[k*8 +: 8];
  end

  // Protocol FSM next-state; shift_q still holds the received byte during the
  // ACK bit, so R/W and write data are taken from it when the ACK bit ends.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    ptr_d     = ptr_q;
    ack_d     = ack_q;
    mack_d    = mack_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    regs_d    = regs_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    ack_bit   = NACK;
    if (start) begin
      state_d   = ADDR;
      bit_cnt_d = '0;
      ack_d     = 1'b0;
      sda_oe_d  = 1'b0;
    end else if (stop) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      ack_d     = 1'b0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (state_q == ADDR || state_q == IDX || state_q == WR) begin
      if (!ack_q && scl_rise && bit_cnt_q != 4'd8) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (!ack_q && scl_fall && bit_cnt_q == 4'd8) begin
        if (state_q == ADDR) begin
          ack_bit = (shift_q[7:1] == DEV_ADDR) ? ACK : NACK;
        end else if (state_q == IDX) begin
          ptr_d   = IDX_W'(shift_q);
          ack_bit = idx_ok ? ACK : NACK;
        end else begin
          ack_bit = ptr_in_rng ? ACK : NACK;
        end
        if (ack_bit == ACK) begin
          sda_oe_d = 1'b1;
          ack_d    = 1'b1;
          if (state_q == ADDR) busy_d = 1'b1;
        end else begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          if (state_q == ADDR) busy_d = 1'b0;
        end
      end else if (ack_q && scl_fall) begin
        sda_oe_d  = 1'b0;
        ack_d     = 1'b0;
        bit_cnt_d = '0;
        if (state_q == ADDR) begin
          if (shift_q[0]) begin
            state_d  = RD;
            tx_d     = rd_src;
            sda_oe_d = ~rd_src[7];
          end else begin
            state_d = IDX;
          end
        end else if (state_q == IDX) begin
          state_d = WR;
        end else begin
          if (ptr_is_rw) begin
            for (int unsigned k = 0; k < N_RW; k++)
              if (ptr_q == IDX_W'(k)) regs_d[k*8 +: 8] = shift_q;
            wr_stb_d  = 1'b1;
            wr_idx_d  = ptr_q;
            wr_data_d = shift_q;
          end
          ptr_d = ptr_inc;
        end
      end
    end else if (state_q == RD) begin
      if (!ack_q) begin
        if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (scl_fall && bit_cnt_q == 4'd8) begin
          sda_oe_d = 1'b0;
          ack_d    = 1'b1;
        end else if (scl_fall) begin
          tx_d     = {tx_q[6:0], 1'b0};
          sda_oe_d = ~tx_q[6];
        end
      end else begin
        if (scl_rise) begin
          mack_d = sda_s;
        end else if (scl_fall) begin
          ack_d     = 1'b0;
          bit_cnt_d = '0;
          if (mack_q == ACK) begin
            ptr_d    = ptr_inc;
            tx_d     = rd_src;
            sda_oe_d = ~rd_src[7];
          end else begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
          end
        end
      end
    end
  end

  // FSM and registered outputs
  always_ff @(posedge clk or posedge start_rst) begin
    if (start_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= '0;
      ptr_q     <= '0;
      ack_q     <= 1'b0;
      mack_q    <= NACK;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      regs_q    <= '0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      mack_q    <= mack_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign regs_o  = regs_q;
  assign wr_stb  = wr_stb_q;
  assign wr_idx  = wr_idx_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: bit-banged I2C master against i2c_reg_slave, checked
// against a register-map model (array + pointer) kept in the bench.
module tb_i2c_reg_slave;
  localparam int N_RW  = 24;
  localparam int N_RO  = 1;
  localparam int IDX_W = 8;
  localparam int TOTAL = N_RW + N_RO;
  localparam int Q     = 8;   // clk cycles per quarter SCL period

  logic              clk = 1'b0;
  logic              start_rst = 1'b1;
  logic              scl_m = 1'b1;
  logic              sda_m = 1'b1;
  logic              sda_bus;
  logic              sda_oe;
  logic [N_RO*8-1:0] status_i = '0;
  logic [N_RW*8-1:0] regs_o;
  logic              wr_stb;
  logic [IDX_W-1:0]  wr_idx;
  logic [7:0]        wr_data;
  logic              busy;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_reg_slave #(.DEV_ADDR(7'h55), .N_RW(N_RW), .N_RO(N_RO), .IDX_W(IDX_W)) dut (
    .clk(clk), .start_rst(start_rst), .scl_i(scl_m), .sda_i(sda_bus),
    .sda_oe(sda_oe), .status_i(status_i), .regs_o(regs_o),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Strobe recorder
  int         stb_cnt = 0;
  logic [7:0] stb_idx = '0;
  logic [7:0] stb_data = '0;
  always @(negedge clk) if (wr_stb) begin
    stb_cnt++;
    stb_idx  = wr_idx;
    stb_data = wr_data;
  end

  // Reference model
  logic [7:0] m_regs [N_RW];
  int         m_ptr = 0;
  int         m_stb = 0;

  function automatic logic [N_RW*8-1:0] model_vec();
    logic [N_RW*8-1:0] v;
    for (int i = 0; i < N_RW; i++) v[i*8 +: 8] = m_regs[i];
    return v;
  endfunction

  function automatic int next_ptr(input int p);
    return (p == TOTAL - 1) ? 0 : (p + 1) % 256;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(2*Q); scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) read_bit(d[i]);
    write_bit(mack);
  endtask

  // Write transaction: index then n data bytes, model updated per register rules
  task automatic do_write(input string tag, input int idx, input int n, input logic [7:0] data [3]);
    logic a;
    i2c_start();
    write_byte(8'hAA, a);
    check({tag, " addr_ack"}, a, 1'b0);
    check({tag, " busy"}, busy, 1'b1);
    write_byte(8'(idx), a);
    check({tag, " idx_ack"}, a, (idx < TOTAL) ? 1'b0 : 1'b1);
    m_ptr = idx;
    if (idx < TOTAL) begin
      for (int i = 0; i < n; i++) begin
        write_byte(data[i], a);
        check({tag, " data_ack"}, a, 1'b0);
        if (m_ptr < N_RW) begin
          m_regs[m_ptr] = data[i];
          m_stb++;
        end
        m_ptr = next_ptr(m_ptr);
      end
    end
    i2c_stop();
    tick(4);
    check({tag, " regs"}, regs_o, model_vec());
    check({tag, " stb_cnt"}, stb_cnt, m_stb);
    check({tag, " busy_end"}, busy, 1'b0);
  endtask

  // Read transaction; idx < 0 reads from the retained pointer
  task automatic do_read(input string tag, input int idx, input int n, output logic [7:0] first);
    logic       a;
    logic [7:0] d;
    logic [7:0] exp;
    status_i = 8'($urandom);
    i2c_start();
    if (idx >= 0) begin
      write_byte(8'hAA, a);
      check({tag, " waddr_ack"}, a, 1'b0);
      write_byte(8'(idx), a);
      check({tag, " idx_ack"}, a, 1'b0);
      m_ptr = idx;
      i2c_start();
    end
    write_byte(8'hAB, a);
    check({tag, " raddr_ack"}, a, 1'b0);
    for (int i = 0; i < n; i++) begin
      read_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      if (m_ptr < N_RW)       exp = m_regs[m_ptr];
      else if (m_ptr < TOTAL) exp = status_i[7:0];
      else                    exp = 8'hFF;
      check({tag, " rd_data"}, d, exp);
      if (i == 0) first = d;
      if (i != n - 1) m_ptr = next_ptr(m_ptr);
    end
    i2c_stop();
    tick(4);
    check({tag, " sda_rel"}, sda_oe, 1'b0);
    check({tag, " busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a;
    logic [7:0] rd;
    logic [7:0] d1, d2;
    logic [7:0] buf3 [3];
    logic [7:0] d4 [3];
    for (int i = 0; i < N_RW; i++) m_regs[i] = 8'h00;

    // Reset state
    tick(3);
    check("rst regs", regs_o, '0);
    check("rst sda_oe", sda_oe, 1'b0);
    check("rst wr_stb", wr_stb, 1'b0);
    check("rst wr_idx", wr_idx, 8'h00);
    check("rst wr_data", wr_data, 8'h00);
    check("rst busy", busy, 1'b0);
    start_rst = 1'b0;
    tick(4);

    // Single write to index 3
    do_write("w3", 3, 1, '{8'h57, 8'h00, 8'h00});
    check("w3 stb_idx", stb_idx, 8'h03);
    check("w3 stb_data", stb_data, 8'h57);
    check("w3 reg3", regs_o[31:24], 8'h57);

    // Index, repeated START, read back
    do_read("r3", 3, 1, rd);
    check("r3 value", rd, 8'h57);

    // Burst starting in the status window wraps to register 0
    d1 = 8'($urandom);
    d2 = 8'($urandom) | 8'h01;
    do_write("wrap", TOTAL - 1, 2, '{d1, d2, 8'h00});
    check("wrap stb_idx", stb_idx, 8'h00);
    check("wrap stb_data", stb_data, d2);
    check("wrap reg0", regs_o[7:0], d2);

    // Foreign address is ignored until the next START
    i2c_start();
    write_byte(8'hA8, a);
    check("foreign addr_ack", a, 1'b1);
    check("foreign busy", busy, 1'b0);
    write_byte(8'h02, a);
    check("foreign idx_ack", a, 1'b1);
    write_byte(8'h99, a);
    check("foreign data_ack", a, 1'b1);
    i2c_stop();
    tick(4);
    check("foreign regs", regs_o, model_vec());
    check("foreign stb_cnt", stb_cnt, m_stb);

    // Out-of-range index is NACKed
    do_write("idxff", 255, 1, '{8'h33, 8'h00, 8'h00});

    // Randomized transactions against the model
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 3; i++) buf3[i] = 8'($urandom);
        do_write("rnd_w", int'($urandom_range(0, TOTAL - 1)), int'($urandom_range(1, 3)), buf3);
      end else begin
        do_read("rnd_r", ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, TOTAL - 1)),
                int'($urandom_range(1, 3)), rd);
      end
    end

    // Make sure some register is non-zero before the reset test
    d4 = '{8'hC3, 8'h00, 8'h00};
    do_write("pre_rst", 7, 1, d4);

    // Reset asserted while the slave drives ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(1'(8'hAA >> i));
    check("ack_drive sda_oe", sda_oe, 1'b1);
    start_rst = 1'b1;
    #1;
    check("rst_mid sda_oe", sda_oe, 1'b0);
    check("rst_mid regs", regs_o, '0);
    check("rst_mid busy", busy, 1'b0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(4);
    start_rst = 1'b0;
    for (int i = 0; i < N_RW; i++) m_regs[i] = 8'h00;
    m_ptr = 0;
    tick(4);

    // Recovery after reset: pointer back at 0
    do_read("post_rst", -1, 2, rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
